// File: rtl/fll_acslip_meter.sv
// Audio-clock slip meter: counts divided I2S word-clock ticks up and divided 16 kHz reference ticks down
// in a saturating signed accumulator, with windowed results, sticky threshold/saturation flags and an irq.
module fll_acslip_meter #(
  parameter int ACC_WIDTH   = 16,
  parameter int DIV_WIDTH   = 8,
  parameter int WIN_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 wbs_clk_i,
  input  logic                 wbs_rst_i,
  input  logic                 acslip_en_i,
  input  logic                 acslip_clr_i,
  input  logic                 i2s_ws_clk_i,
  input  logic                 sys_ref_clk_16khz_i,
  input  logic [DIV_WIDTH-1:0] i2s_div_i,
  input  logic [DIV_WIDTH-1:0] ref_div_i,
  input  logic [WIN_WIDTH-1:0] win_len_i,
  input  logic [ACC_WIDTH-1:0] thresh_i,
  output logic [ACC_WIDTH-1:0] slip_acc_o,
  output logic [ACC_WIDTH-1:0] slip_win_o,
  output logic                 win_done_o,
  output logic                 slip_fast_o,
  output logic                 slip_slow_o,
  output logic                 sat_o,
  output logic                 irq_o
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = 1;

  logic [SYNC_STAGES-1:0]      ws_sync, ref_sync;
  logic                        ws_last, ref_last;
  logic                        ws_edge, ref_edge;
  logic [DIV_WIDTH-1:0]        ws_cnt, ref_cnt;
  logic                        i2s_tick, ref_tick;
  logic [WIN_WIDTH-1:0]        win_cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_step, slip_win;
  logic                        step_blocked, win_end;
  logic signed [ACC_WIDTH:0]   acc_ext, thresh_pos;
  logic                        hit_fast, hit_slow;
  logic                        win_done, fast_flag, slow_flag, sat_flag;

  // Synchronisers run independently of enable and clear so no false edge appears on enabling.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      ws_sync  <= '0;
      ref_sync <= '0;
      ws_last  <= 1'b0;
      ref_last <= 1'b0;
    end else begin
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws_clk_i};
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], sys_ref_clk_16khz_i};
      ws_last  <= ws_sync[SYNC_STAGES-1];
      ref_last <= ref_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    ws_edge      = ws_sync[SYNC_STAGES-1] & ~ws_last;
    ref_edge     = ref_sync[SYNC_STAGES-1] & ~ref_last;
    i2s_tick     = acslip_en_i & ws_edge & (ws_cnt >= i2s_div_i);
    ref_tick     = acslip_en_i & ref_edge & (ref_cnt >= ref_div_i);
    acc_step     = acc;
    step_blocked = 1'b0;
    if (i2s_tick && !ref_tick) begin
      if (acc == ACC_MAX) step_blocked = 1'b1;
      else acc_step = acc + ACC_ONE;
    end else if (ref_tick && !i2s_tick) begin
      if (acc == ACC_MIN) step_blocked = 1'b1;
      else acc_step = acc - ACC_ONE;
    end
    win_end    = ref_tick && (win_len_i != '0) && (win_cnt == win_len_i - 1'b1);
    // One extra bit lets the full unsigned threshold magnitude be compared on both signs.
    acc_ext    = {acc_step[ACC_WIDTH-1], acc_step};
    thresh_pos = $signed({1'b0, thresh_i});
    hit_fast   = (thresh_i != '0) && (acc_ext >= thresh_pos);
    hit_slow   = (thresh_i != '0) && (acc_ext <= -thresh_pos);
  end

  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      ws_cnt    <= '0;
      ref_cnt   <= '0;
      win_cnt   <= '0;
      acc       <= '0;
      slip_win  <= '0;
      win_done  <= 1'b0;
      fast_flag <= 1'b0;
      slow_flag <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (acslip_clr_i) begin
      ws_cnt    <= '0;
      ref_cnt   <= '0;
      win_cnt   <= '0;
      acc       <= '0;
      slip_win  <= '0;
      win_done  <= 1'b0;
      fast_flag <= 1'b0;
      slow_flag <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      win_done <= win_end;
      if (hit_fast)     fast_flag <= 1'b1;
      if (hit_slow)     slow_flag <= 1'b1;
      if (step_blocked) sat_flag  <= 1'b1;
      if (!acslip_en_i) begin
        ws_cnt  <= '0;
        ref_cnt <= '0;
        win_cnt <= '0;
        acc     <= '0;
      end else begin
        if (ws_edge)  ws_cnt  <= i2s_tick ? '0 : ws_cnt + 1'b1;
        if (ref_edge) ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
        if (win_end) begin
          slip_win <= acc_step;
          acc      <= '0;
          win_cnt  <= '0;
        end else begin
          acc <= acc_step;
          if (ref_tick && (win_len_i != '0)) win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

  assign slip_acc_o  = acc;
  assign slip_win_o  = slip_win;
  assign win_done_o  = win_done;
  assign slip_fast_o = fast_flag;
  assign slip_slow_o = slow_flag;
  assign sat_o       = sat_flag;
  assign irq_o       = fast_flag | slow_flag | sat_flag;

endmodule

// File: tb/tb_fll_acslip_meter.sv
// Self-checking bench for fll_acslip_meter: directed scenarios plus randomized rounds checked against a
// tick-counting reference model, with window results scoreboarded through a queue.
module tb_fll_acslip_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        ws = 1'b0;
  logic        ref_clk = 1'b0;
  logic [7:0]  i2s_div = 8'd0;
  logic [7:0]  ref_div = 8'd0;
  logic [15:0] win_len = 16'd0;
  logic [15:0] thresh = 16'd0;
  logic [3:0]  thresh4 = 4'd0;

  logic signed [15:0] acc, win_res;
  logic               win_done, fast, slow, sat, irq;
  logic signed [3:0]  acc4, win4;
  logic               win_done4, fast4, slow4, sat4, irq4;

  int n_checks = 0;
  int n_pass = 0;
  int exp_q[$];

  fll_acslip_meter dut (
    .wbs_clk_i(clk), .wbs_rst_i(rst), .acslip_en_i(en), .acslip_clr_i(clr),
    .i2s_ws_clk_i(ws), .sys_ref_clk_16khz_i(ref_clk),
    .i2s_div_i(i2s_div), .ref_div_i(ref_div), .win_len_i(win_len), .thresh_i(thresh),
    .slip_acc_o(acc), .slip_win_o(win_res), .win_done_o(win_done),
    .slip_fast_o(fast), .slip_slow_o(slow), .sat_o(sat), .irq_o(irq)
  );

  // Narrow instance sharing the stimulus, used to reach the accumulator rails quickly.
  fll_acslip_meter #(.ACC_WIDTH(4)) dut4 (
    .wbs_clk_i(clk), .wbs_rst_i(rst), .acslip_en_i(en), .acslip_clr_i(clr),
    .i2s_ws_clk_i(ws), .sys_ref_clk_16khz_i(ref_clk),
    .i2s_div_i(i2s_div), .ref_div_i(ref_div), .win_len_i(win_len), .thresh_i(thresh4),
    .slip_acc_o(acc4), .slip_win_o(win4), .win_done_o(win_done4),
    .slip_fast_o(fast4), .slip_slow_o(slow4), .sat_o(sat4), .irq_o(irq4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Every win_done pulse must match the oldest expected window result.
  initial begin
    forever begin
      @(negedge clk);
      if (win_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL win_unexpected: got pulse with slip_win %0d expected no pulse", win_res);
        end else begin
          checkOutput("slip_win", longint'(win_res), longint'(exp_q.pop_front()));
        end
      end
    end
  end

  // One rising edge on the chosen inputs, held long enough for the tick to land.
  task automatic applyStimulus(input bit w, input bit r);
    @(posedge clk); #2;
    ws = w; ref_clk = r;
    repeat (5) @(posedge clk);
    #2;
    ws = 1'b0; ref_clk = 1'b0;
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
  endtask

  task automatic setup(input int idiv, input int rdiv, input int wlen, input int th);
    @(posedge clk); #2;
    i2s_div = 8'(idiv); ref_div = 8'(rdiv); win_len = 16'(wlen); thresh = 16'(th);
    en = 1'b1;
    pulse_clear();
  endtask

  // Reference model: the n-th edge ticks when n is a multiple of (div+1); window closes every wlen ref ticks.
  task automatic random_round();
    int idiv, rdiv, wlen, th, wsn, rn, macc, sel;
    bit mf, ms, w, r, ti, tr;
    idiv = $urandom_range(0, 3);
    rdiv = $urandom_range(0, 2);
    wlen = $urandom_range(1, 5);
    th   = $urandom_range(1, 6);
    setup(idiv, rdiv, wlen, th);
    wsn = 0; rn = 0; macc = 0; mf = 0; ms = 0;
    for (int k = 0; k < 120; k++) begin
      sel = $urandom_range(0, 4);
      w = (sel < 2) || (sel == 4);
      r = (sel >= 2);
      ti = 0; tr = 0;
      if (w) begin wsn++; ti = (wsn % (idiv + 1)) == 0; end
      if (r) begin rn++; tr = (rn % (rdiv + 1)) == 0; end
      if (ti && !tr) macc++;
      if (tr && !ti) macc--;
      if (macc >= th) mf = 1;
      if (macc <= -th) ms = 1;
      if (tr) begin
        if (((rn / (rdiv + 1)) % wlen) == 0) begin
          exp_q.push_back(macc);
          macc = 0;
        end
      end
      applyStimulus(w, r);
    end
    @(negedge clk);
    checkOutput("rand_acc", longint'(acc), longint'(macc));
    checkOutput("rand_fast", longint'(fast), longint'(mf));
    checkOutput("rand_slow", longint'(slow), longint'(ms));
    checkOutput("rand_irq", longint'(irq), longint'(mf | ms));
    checkOutput("rand_queue_drained", longint'(exp_q.size()), 0);
  endtask

  initial begin
    bit seen_plus;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_acc", longint'(acc), 0);
    checkOutput("rst_win", longint'(win_res), 0);
    checkOutput("rst_done", longint'(win_done), 0);
    checkOutput("rst_irq", longint'(irq), 0);

    // I2S fast: 30 edges at div3 with no reference give +10, crossing +8 on the 24th edge.
    setup(2, 0, 0, 8);
    for (int i = 0; i < 21; i++) applyStimulus(1, 0);
    @(negedge clk);
    checkOutput("fast_acc7", longint'(acc), 7);
    checkOutput("fast_not_yet", longint'(fast), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0);
    @(negedge clk);
    checkOutput("fast_at8", longint'(fast), 1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0);
    @(negedge clk);
    checkOutput("fast_acc10", longint'(acc), 10);
    checkOutput("fast_irq", longint'(irq), 1);
    checkOutput("fast_no_slow", longint'(slow), 0);

    // Narrow accumulator rails at -8 and raises sat; clear drops both.
    setup(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("sat4_acc", longint'(acc4), -8);
    checkOutput("sat4_flag", longint'(sat4), 1);
    checkOutput("sat4_irq", longint'(irq4), 1);
    checkOutput("sat16_acc", longint'(acc), -10);
    checkOutput("sat16_none", longint'(sat), 0);
    pulse_clear();
    @(negedge clk);
    checkOutput("sat4_clr_acc", longint'(acc4), 0);
    checkOutput("sat4_clr_flag", longint'(sat4), 0);

    // Window of 4 ref ticks with 6 I2S ticks closes at +2.
    setup(0, 0, 4, 0);
    exp_q.push_back(2);
    applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(0, 1);
    applyStimulus(1, 0); applyStimulus(0, 1); applyStimulus(1, 0);
    applyStimulus(0, 1); applyStimulus(1, 0); applyStimulus(1, 0);
    applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("win_acc_zero", longint'(acc), 0);
    checkOutput("win_latched", longint'(win_res), 2);

    // Aligned ticks cancel; a one-cycle skew shows +1 then returns to 0.
    setup(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1);
    @(negedge clk);
    checkOutput("aligned_acc", longint'(acc), 0);
    @(posedge clk); #2 ws = 1'b1;
    @(posedge clk); #2 ref_clk = 1'b1;
    seen_plus = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (acc == 16'sd1) seen_plus = 1;
    end
    ws = 1'b0; ref_clk = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("skew_saw_plus1", longint'(seen_plus), 1);
    checkOutput("skew_acc_back", longint'(acc), 0);

    for (int r = 0; r < 4; r++) random_round();

    // Disabled meter ignores toggling inputs.
    setup(0, 0, 0, 1);
    #1 en = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1, 0);
    applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("dis_acc", longint'(acc), 0);
    checkOutput("dis_fast", longint'(fast), 0);
    checkOutput("dis_slow", longint'(slow), 0);

    // Async reset in the middle of a window returns everything to 0 without waiting for a clock.
    setup(0, 0, 2, 2);
    exp_q.push_back(1);
    applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(1, 0);
    applyStimulus(0, 1); applyStimulus(0, 1);
    applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("pre_rst_acc", longint'(acc), 1);
    checkOutput("pre_rst_win", longint'(win_res), 1);
    checkOutput("pre_rst_irq", longint'(irq), 1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checkOutput("midrst_acc", longint'(acc), 0);
    checkOutput("midrst_win", longint'(win_res), 0);
    checkOutput("midrst_fast", longint'(fast), 0);
    checkOutput("midrst_irq", longint'(irq), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_acc", longint'(acc), 0);
    checkOutput("final_queue", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
